// File: rtl/bram_loader_pkg.sv
// Shared types and constants for the BRAM stream loader: FSM state encoding and counter widths.
package bram_loader_pkg;

  localparam int STATE_W       = 3;
  localparam int TIMEOUT_CNT_W = 32;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE,
    S_RESTARTING,
    S_RECEIVE,
    S_FLUSH,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/byte_word_packer.sv
// Assembles a byte stream into BRAM words: lane sequencing, endianness and zero padding of partial words.
module byte_word_packer
  import bram_loader_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTE = 3,
  parameter bit BIG_ENDIAN         = 1'b0
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            clear,
  input  logic                            byte_valid,
  input  logic [7:0]                      byte_in,
  output logic                            word_done,
  output logic                            partial_valid,
  output logic [8*DATA_WIDTH_IN_BYTE-1:0] word_out
);

  localparam int                LANE_W    = (DATA_WIDTH_IN_BYTE > 1) ? $clog2(DATA_WIDTH_IN_BYTE) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(DATA_WIDTH_IN_BYTE - 1);

  logic [LANE_W-1:0]               lane;
  logic [LANE_W-1:0]               pos;
  logic [8*DATA_WIDTH_IN_BYTE-1:0] word_q;

  // word_out is the stored partial word (unfilled lanes already zero) with this cycle's byte merged in.
  // NOTE: every variable in an always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    pos       = BIG_ENDIAN ? (LAST_LANE - lane) : lane;
    word_out  = word_q;
    word_done = byte_valid && (lane == LAST_LANE);
    for (int i = 0; i < DATA_WIDTH_IN_BYTE; i++) begin
      if (byte_valid && (pos == LANE_W'(i))) word_out[8*i +: 8] = byte_in;
    end
  end

  assign partial_valid = (lane != '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lane   <= '0;
      word_q <= '0;
    end else if (clear) begin
      lane   <= '0;
      word_q <= '0;
    end else if (byte_valid) begin
      if (lane == LAST_LANE) begin
        lane   <= '0;
        word_q <= '0;
      end else begin
        lane   <= lane + 1'b1;
        word_q <= word_out;
      end
    end
  end

endmodule

// File: rtl/bram_stream_loader.sv
// Loads a CPU byte stream into BRAM words with restart/timeout/retry handling.
// Optional checksum_out port is enabled by defining BRAM_LOADER_CHECKSUM_EN.
module bram_stream_loader
  import bram_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH           = 13,
  parameter int         DATA_WIDTH_IN_BYTE   = 3,
  parameter logic [7:0] STATIC_INIT_AUX_INFO = 8'h00,
  parameter int         RESTARTING_TIMEOUT   = 5,
  parameter int         IDLE_TIMEOUT         = 1000,
  parameter int         MAX_RETRIES          = 2,
  parameter bit         BIG_ENDIAN           = 1'b0
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            sig_on,
  output logic                            sig_done,
  output logic                            sig_error,
  output logic [ADDR_WIDTH-1:0]           bram_addr_w,
  output logic [8*DATA_WIDTH_IN_BYTE-1:0] bram_data_in,
  output logic                            bram_en_w,
  output logic                            restart,
  output logic [7:0]                      init_index,
  output logic [7:0]                      init_aux_info,
  output logic                            request_data,
  input  logic                            data_ready,
  input  logic [7:0]                      cpu_data_in,
  input  logic                            transmit_finished,
  input  logic [7:0]                      song_selection,
  output logic [ADDR_WIDTH:0]             word_count,
  output logic                            overflow
`ifdef BRAM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]                      checksum_out
`endif
);

  localparam logic [TIMEOUT_CNT_W-1:0] RESTART_LAST = TIMEOUT_CNT_W'(RESTARTING_TIMEOUT - 1);
  localparam logic [TIMEOUT_CNT_W-1:0] IDLE_LAST    = TIMEOUT_CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [7:0]               RETRY_MAX    = 8'(MAX_RETRIES);

  state_t                          state, state_n;
  logic [TIMEOUT_CNT_W-1:0]        tmo_cnt;
  logic [7:0]                      retry_cnt;
  logic                            start, timeout, retry;
  logic                            byte_take, full, write;
  logic                            word_done, partial_valid;
  logic [8*DATA_WIDTH_IN_BYTE-1:0] word_out;

  // Once the address space is exhausted, bytes are still consumed but never packed.
  assign full      = word_count[ADDR_WIDTH];
  assign byte_take = (state == S_RECEIVE) && data_ready;
  assign write     = !full && (word_done || ((state == S_FLUSH) && partial_valid));

  assign restart       = (state == S_RESTARTING);
  assign request_data  = (state == S_RECEIVE);
  assign init_aux_info = STATIC_INIT_AUX_INFO;

  byte_word_packer #(
    .DATA_WIDTH_IN_BYTE(DATA_WIDTH_IN_BYTE),
    .BIG_ENDIAN        (BIG_ENDIAN)
  ) u_packer (
    .CLK          (CLK),
    .RESET        (RESET),
    .clear        (start || timeout || (state == S_FLUSH)),
    .byte_valid   (byte_take && !full),
    .byte_in      (cpu_data_in),
    .word_done    (word_done),
    .partial_valid(partial_valid),
    .word_out     (word_out)
  );

  always_comb begin
    state_n = state;
    start   = 1'b0;
    timeout = 1'b0;
    retry   = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (sig_on) begin
          start   = 1'b1;
          state_n = S_RESTARTING;
        end
      end
      S_RESTARTING: if (tmo_cnt == RESTART_LAST) state_n = S_RECEIVE;
      S_RECEIVE: begin
        // A byte arriving with transmit_finished is still taken via byte_take.
        if (transmit_finished) begin
          state_n = S_FLUSH;
        end else if (!data_ready && (tmo_cnt == IDLE_LAST)) begin
          timeout = 1'b1;
          if (retry_cnt < RETRY_MAX) begin
            retry   = 1'b1;
            state_n = S_RESTARTING;
          end else begin
            state_n = S_ERROR;
          end
        end
      end
      S_FLUSH: state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= S_IDLE;
      tmo_cnt      <= '0;
      retry_cnt    <= '0;
      word_count   <= '0;
      overflow     <= 1'b0;
      sig_error    <= 1'b0;
      sig_done     <= 1'b0;
      init_index   <= '0;
      bram_en_w    <= 1'b0;
      bram_addr_w  <= '0;
      bram_data_in <= '0;
    end else begin
      state     <= state_n;
      sig_done  <= (state == S_FLUSH);
      bram_en_w <= write;

      if (state_n != state)                               tmo_cnt <= '0;
      else if (state == S_RESTARTING)                     tmo_cnt <= tmo_cnt + 1'b1;
      else if (state == S_RECEIVE)                        tmo_cnt <= data_ready ? '0 : tmo_cnt + 1'b1;
      else                                                tmo_cnt <= '0;

      if (start)      retry_cnt <= '0;
      else if (retry) retry_cnt <= retry_cnt + 1'b1;

      if (write) begin
        bram_addr_w  <= word_count[ADDR_WIDTH-1:0];
        bram_data_in <= word_out;
      end

      if (start || retry) word_count <= '0;
      else if (write)     word_count <= word_count + 1'b1;

      if (start)                  overflow <= 1'b0;
      else if (byte_take && full) overflow <= 1'b1;

      if (start)                                        sig_error <= 1'b0;
      else if (timeout && (state_n == S_ERROR))         sig_error <= 1'b1;

      if (start) init_index <= song_selection;
    end
  end

`ifdef BRAM_LOADER_CHECKSUM_EN
  // Only bytes taken in RECEIVE contribute, so the sum holds steady from sig_done to the next start.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)              checksum_out <= '0;
    else if (start || retry) checksum_out <= '0;
    else if (byte_take)     checksum_out <= checksum_out + cpu_data_in;
  end
`endif

endmodule

// File: tb/tb_bram_stream_loader.sv
// Scoreboard bench for bram_stream_loader: dut_a (defaults, short idle timeout), dut_b (2-bit address, big-endian).
module tb_bram_stream_loader;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [13:0] addr;
    logic [23:0] data;
  } wr_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] cpu_data_in, song_selection;
  logic [1:0] sig_on, data_ready, transmit_finished;

  logic        done_a, err_a, en_a, restart_a, req_a, ovf_a;
  logic [12:0] addr_a;
  logic [23:0] data_a;
  logic [7:0]  idx_a, aux_a, cks_a;
  logic [13:0] wc_a;
  logic        done_b, err_b, en_b, restart_b, req_b, ovf_b;
  logic [1:0]  addr_b;
  logic [23:0] data_b;
  logic [7:0]  idx_b, aux_b, cks_b;
  logic [2:0]  wc_b;

  int  checks = 0, failures = 0;
  int  wr_cnt[2], done_cnt[2], rs_cnt[2], rh_cnt[2];
  logic rs_prev[2];
  wr_t q_a[$], q_b[$];
  wr_t exp_a, exp_b;

  always #5 CLK = ~CLK;

  bram_stream_loader #(.IDLE_TIMEOUT(20)) dut_a (
    .CLK(CLK), .RESET(RESET), .sig_on(sig_on[0]), .sig_done(done_a), .sig_error(err_a),
    .bram_addr_w(addr_a), .bram_data_in(data_a), .bram_en_w(en_a), .restart(restart_a),
    .init_index(idx_a), .init_aux_info(aux_a), .request_data(req_a), .data_ready(data_ready[0]),
    .cpu_data_in(cpu_data_in), .transmit_finished(transmit_finished[0]),
    .song_selection(song_selection), .word_count(wc_a), .overflow(ovf_a)
`ifdef BRAM_LOADER_CHECKSUM_EN
    , .checksum_out(cks_a)
`endif
  );

  bram_stream_loader #(.ADDR_WIDTH(2), .BIG_ENDIAN(1'b1), .STATIC_INIT_AUX_INFO(8'h5A), .IDLE_TIMEOUT(20)) dut_b (
    .CLK(CLK), .RESET(RESET), .sig_on(sig_on[1]), .sig_done(done_b), .sig_error(err_b),
    .bram_addr_w(addr_b), .bram_data_in(data_b), .bram_en_w(en_b), .restart(restart_b),
    .init_index(idx_b), .init_aux_info(aux_b), .request_data(req_b), .data_ready(data_ready[1]),
    .cpu_data_in(cpu_data_in), .transmit_finished(transmit_finished[1]),
    .song_selection(song_selection), .word_count(wc_b), .overflow(ovf_b)
`ifdef BRAM_LOADER_CHECKSUM_EN
    , .checksum_out(cks_b)
`endif
  );

`ifndef BRAM_LOADER_CHECKSUM_EN
  assign cks_a = 8'h00;
  assign cks_b = 8'h00;
`endif

  // Write monitor: every bram_en_w pulse must match the oldest expected write.
  always @(negedge CLK) begin
    if (en_a) begin
      checks++;
      wr_cnt[0]++;
      if (q_a.size() == 0) begin
        failures++;
        $display("FAIL write_a unexpected: addr=%0d data=%h", addr_a, data_a);
      end else begin
        exp_a = q_a.pop_front();
        if (addr_a !== exp_a.addr[12:0] || data_a !== exp_a.data) begin
          failures++;
          $display("FAIL write_a: got addr=%0d data=%h, expected addr=%0d data=%h",
                   addr_a, data_a, exp_a.addr, exp_a.data);
        end
      end
    end
    if (en_b) begin
      checks++;
      wr_cnt[1]++;
      if (q_b.size() == 0) begin
        failures++;
        $display("FAIL write_b unexpected: addr=%0d data=%h", addr_b, data_b);
      end else begin
        exp_b = q_b.pop_front();
        if (addr_b !== exp_b.addr[1:0] || data_b !== exp_b.data) begin
          failures++;
          $display("FAIL write_b: got addr=%0d data=%h, expected addr=%0d data=%h",
                   addr_b, data_b, exp_b.addr, exp_b.data);
        end
      end
    end
    if (done_a) done_cnt[0]++;
    if (done_b) done_cnt[1]++;
    if (restart_a) rh_cnt[0]++;
    if (restart_b) rh_cnt[1]++;
    if (restart_a && !rs_prev[0]) rs_cnt[0]++;
    if (restart_b && !rs_prev[1]) rs_cnt[1]++;
    rs_prev[0] = restart_a;
    rs_prev[1] = restart_b;
  end

  function automatic byte_q_t ramp(input logic [7:0] first, input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(first + 8'(i));
    return q;
  endfunction

  task automatic clear_counts(input int s);
    wr_cnt[s] = 0; done_cnt[s] = 0; rs_cnt[s] = 0; rh_cnt[s] = 0;
  endtask

  task automatic pulse_start(input int s, input logic [7:0] song);
    @(posedge CLK); #1;
    song_selection = song;
    sig_on[s]      = 1'b1;
    @(posedge CLK); #1;
    sig_on[s] = 1'b0;
  endtask

  task automatic wait_receive(input int s);
    logic seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLK); #1;
      seen = (s == 0) ? req_a : req_b;
    end
    checks++;
    if (seen !== 1'b1) begin
      failures++;
      $display("FAIL request_data_%0d: got %b within 50 cycles, expected 1", s, seen);
    end
  endtask

  task automatic send_list(input int s, input byte_q_t bytes, input int gap);
    foreach (bytes[i]) begin
      @(posedge CLK); #1;
      cpu_data_in   = bytes[i];
      data_ready[s] = 1'b1;
      if (gap > 0) begin
        @(posedge CLK); #1;
        data_ready[s] = 1'b0;
        repeat (gap - 1) @(posedge CLK);
      end
    end
    @(posedge CLK); #1;
    data_ready[s] = 1'b0;
  endtask

  task automatic finish_tx(input int s);
    @(posedge CLK); #1;
    transmit_finished[s] = 1'b1;
    @(posedge CLK); #1;
    transmit_finished[s] = 1'b0;
    repeat (6) @(negedge CLK);
    #1;
  endtask

  task automatic check_load(input int s, input int exp_writes, input int exp_wc, input logic exp_ovf,
                            input logic [7:0] exp_cks);
    int       wc;
    logic     ovf;
    logic [7:0] cks;
    wc  = (s == 0) ? int'(wc_a) : int'(wc_b);
    ovf = (s == 0) ? ovf_a : ovf_b;
    cks = (s == 0) ? cks_a : cks_b;
    checks += 5;
    if (wr_cnt[s] !== exp_writes) begin
      failures++; $display("FAIL writes_%0d: got %0d, expected %0d", s, wr_cnt[s], exp_writes);
    end
    if (wc !== exp_wc) begin
      failures++; $display("FAIL word_count_%0d: got %0d, expected %0d", s, wc, exp_wc);
    end
    if (ovf !== exp_ovf) begin
      failures++; $display("FAIL overflow_%0d: got %b, expected %b", s, ovf, exp_ovf);
    end
    if (done_cnt[s] !== 1) begin
      failures++; $display("FAIL sig_done_%0d: got %0d pulses, expected 1", s, done_cnt[s]);
    end
    if (((s == 0) ? q_a.size() : q_b.size()) != 0) begin
      failures++; $display("FAIL pending_writes_%0d: expected writes never appeared", s);
    end
`ifdef BRAM_LOADER_CHECKSUM_EN
    checks++;
    if (cks !== exp_cks) begin
      failures++; $display("FAIL checksum_%0d: got %0d, expected %0d", s, cks, exp_cks);
    end
`else
    if (cks !== cks) $display("unreachable %0d", exp_cks);
`endif
  endtask

  task automatic check_a_zero(input string tag);
    checks += 3;
    if ({done_a, err_a, en_a, restart_a, req_a, ovf_a} !== 6'b0) begin
      failures++;
      $display("FAIL %s flags: got %b, expected 000000", tag, {done_a, err_a, en_a, restart_a, req_a, ovf_a});
    end
    if (wc_a !== 14'd0 || addr_a !== 13'd0 || data_a !== 24'd0 || idx_a !== 8'd0) begin
      failures++;
      $display("FAIL %s regs: wc=%0d addr=%0d data=%h idx=%h, expected all 0", tag, wc_a, addr_a, data_a, idx_a);
    end
    if (aux_a !== 8'h00) begin
      failures++; $display("FAIL %s aux_a: got %h, expected 00", tag, aux_a);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #12;
    check_a_zero("reset");
    checks += 2;
    if ({done_b, err_b, en_b, restart_b, req_b, ovf_b} !== 6'b0 || wc_b !== 3'd0) begin
      failures++; $display("FAIL reset_b: got flags %b wc=%0d, expected 0", {done_b, err_b, en_b, restart_b, req_b, ovf_b}, wc_b);
    end
    if (aux_b !== 8'h5A) begin
      failures++; $display("FAIL aux_b: got %h, expected 5a", aux_b);
    end
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_defaults();
    clear_counts(0);
    pulse_start(0, 8'h07);
    wait_receive(0);
    checks += 2;
    if (rh_cnt[0] !== 5) begin
      failures++; $display("FAIL restart_len: got %0d cycles, expected 5", rh_cnt[0]);
    end
    if (idx_a !== 8'h07) begin
      failures++; $display("FAIL init_index: got %h, expected 07", idx_a);
    end
    q_a.push_back('{14'd0, 24'h030201});
    q_a.push_back('{14'd1, 24'h060504});
    q_a.push_back('{14'd2, 24'h090807});
    q_a.push_back('{14'd3, 24'h0C0B0A});
    send_list(0, ramp(8'd1, 12), 1);
    finish_tx(0);
    check_load(0, 4, 4, 1'b0, 8'd78);
  endtask

  task automatic test_back_to_back();
    clear_counts(0);
    pulse_start(0, 8'h11);
    wait_receive(0);
    q_a.push_back('{14'd0, 24'h030201});
    q_a.push_back('{14'd1, 24'h060504});
    send_list(0, ramp(8'd1, 6), 0);
    finish_tx(0);
    check_load(0, 2, 2, 1'b0, 8'd21);
  endtask

  task automatic test_timeout();
    clear_counts(0);
    pulse_start(0, 8'h22);
    for (int i = 0; i < 200 && err_a !== 1'b1; i++) @(negedge CLK);
    #1;
    checks += 4;
    if (err_a !== 1'b1) begin
      failures++; $display("FAIL sig_error: got %b, expected 1", err_a);
    end
    if (rs_cnt[0] !== 3) begin
      failures++; $display("FAIL restart_pulses: got %0d, expected 3", rs_cnt[0]);
    end
    if (req_a !== 1'b0 || restart_a !== 1'b0) begin
      failures++; $display("FAIL error_outputs: request_data=%b restart=%b, expected 0 0", req_a, restart_a);
    end
    if (wr_cnt[0] !== 0) begin
      failures++; $display("FAIL timeout_writes: got %0d, expected 0", wr_cnt[0]);
    end
  endtask

  task automatic test_reset_mid_load();
    clear_counts(0);
    pulse_start(0, 8'h33);
    wait_receive(0);
    send_list(0, ramp(8'h50, 2), 0);
    @(posedge CLK); #2;
    RESET = 1'b1;
    #1;
    check_a_zero("reset_mid");
    @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    clear_counts(0);
    pulse_start(0, 8'h44);
    wait_receive(0);
    q_a.push_back('{14'd0, 24'h232221});
    send_list(0, ramp(8'h21, 3), 0);
    finish_tx(0);
    check_load(0, 1, 1, 1'b0, 8'h66);
  endtask

  task automatic test_big_endian();
    byte_q_t b;
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    clear_counts(1);
    pulse_start(1, 8'h01);
    wait_receive(1);
    q_b.push_back('{14'd0, 24'hAABBCC});
    q_b.push_back('{14'd1, 24'hDD0000});
    send_list(1, b, 2);
    finish_tx(1);
    check_load(1, 2, 2, 1'b0, 8'h0E);
  endtask

  task automatic test_overflow();
    clear_counts(1);
    pulse_start(1, 8'h02);
    wait_receive(1);
    q_b.push_back('{14'd0, 24'h010203});
    q_b.push_back('{14'd1, 24'h040506});
    q_b.push_back('{14'd2, 24'h070809});
    q_b.push_back('{14'd3, 24'h0A0B0C});
    send_list(1, ramp(8'd1, 15), 0);
    finish_tx(1);
    check_load(1, 4, 4, 1'b1, 8'd120);
  endtask

  initial begin
    sig_on = '0; data_ready = '0; transmit_finished = '0;
    cpu_data_in = '0; song_selection = '0;
    rs_prev[0] = 1'b0; rs_prev[1] = 1'b0;
    clear_counts(0); clear_counts(1);
    test_reset();
    test_defaults();
    test_back_to_back();
    test_timeout();
    test_reset_mid_load();
    test_big_endian();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
